uart_rx_capture: RTL
====================

Name: uart_rx_capture

Overview:
- Receives the serial byte stream that chip_top drives on its UART txd pin and turns it into a byte stream with a valid/ready handshake.
- Sits directly downstream of chip_top in FPGA simulation and bring-up benches, acting as the console sink.
- Performs its own input synchronisation, mid-bit sampling, and framing checks.
- Buffers received bytes in a small FIFO and reports framing errors and overruns.

Parameters:
- FIFO_DEPTH, 8, number of buffered bytes; must be a power of 2 and at least 2.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset; sampled on the rising edge of clk
- rxd  in  1  serial line from chip_top txd; idle high; asynchronous to clk
- baud_div  in  DIV_W  clk cycles per bit; legal range 4 to 2^DIV_W-1
- out_data  out  8  byte at the FIFO head
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: byte completed while FIFO full; byte dropped
- err_cnt  out  8  saturating count of frame_err plus overrun events
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rstn low at a clk edge):
  - FSM goes to IDLE.
  - FIFO is emptied; out_valid=0, out_data=0.
  - frame_err=0, overrun=0, err_cnt=0, busy=0.
  - Synchroniser flops are set to 1.
  - Reset asserted mid-frame abandons the frame; no partial byte is ever pushed.
- Synchronisation: rxd passes through 2 flops to give rxs. All decisions use rxs, so line events are seen 2 cycles late.
- Divisor latch: baud_div is captured into div_q on IDLE->START. Changes to baud_div mid-frame have no effect until the next frame.
- Bit counter: cnt counts down. Half-bit = div_q>>1 (truncating). Full bit = div_q.
- IDLE:
  - rxs==0 -> START, cnt=half-1.
- START:
  - Decrement cnt.
  - At cnt==0: if rxs==0 -> DATA, cnt=div_q-1, bit index=0.
  - If rxs==1 -> IDLE (glitch rejected; no error raised).
- DATA:
  - At cnt==0: shift rxs into shreg[7], shifting right, so bits arrive LSB first. Reload cnt=div_q-1.
  - After the 8th sample -> STOP.
- STOP:
  - At cnt==0, sample rxs.
  - rxs==1, FIFO not full: push shreg, go to IDLE.
  - rxs==1, FIFO full: pulse overrun, drop the byte, go to IDLE.
  - rxs==0: pulse frame_err, discard the byte, go to BREAK.
- BREAK:
  - Stay until rxs==1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- Latency: out_valid rises the cycle after the stop-bit sample edge, provided the FIFO was empty.
- FIFO:
  - out_data is registered, or a direct read of the head entry with no bubble.
  - Pop on out_valid && out_ready.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full. In that case the pop happens first, so the push succeeds and overrun is not raised.
- err_cnt:
  - Increments by 1 per frame_err or overrun pulse. Both cannot occur in the same cycle.
  - Saturates at 255.
- busy = (state != IDLE).

Test Plan:
- baud_div=8; send 0x55 (start, 1010_1010 LSB first, stop), out_ready=1 -> out_data=0x55 with out_valid for 1 cycle; frame_err=0.
- baud_div=8; send 0xA3,0x00,0xFF back-to-back (no idle gap), out_ready=0 -> FIFO holds 3 entries. Then raise out_ready -> pops 0xA3,0x00,0xFF in order.
- baud_div=8; drive rxd low for 3 cycles then high -> glitch rejected; no push, no error; busy returns low.
- baud_div=8; send 0x41 with stop bit low, then hold rxd low 40 cycles -> exactly one frame_err pulse, err_cnt=1, FIFO stays empty. Next good frame 0x42 is received.
- FIFO_DEPTH=8, out_ready=0; send 9 bytes 0x01..0x09 -> 8 entries held, overrun pulses once, err_cnt=1. Drain yields 0x01..0x08.
- Assert rstn low during DATA of a frame and release -> out_valid=0 and err_cnt=0 afterwards. The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: UART receiver with 2-flop input sync, mid-bit sampling, framing checks and a byte FIFO.
module uart_rx_capture #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rxd,
  input  logic [DIV_W-1:0] baud_div,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic [7:0]       err_cnt,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic rx_m, rxs;
  logic [DIV_W-1:0] cnt, cnt_n, div_q;
  logic [2:0] bidx, bidx_n;
  logic [7:0] shreg, shreg_n;
  logic push, ferr_n, ovr_n, pop, full, cnt_zero;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  assign pop = out_valid && out_ready;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign out_valid = count != '0;
  assign out_data = out_valid ? mem[rp] : 8'h00;
  assign busy = state != IDLE;
  assign cnt_zero = cnt == '0;
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else state <= state_n;
  end
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bidx_n = bidx;
    shreg_n = shreg;
    push = 1'b0;
    ferr_n = 1'b0;
    ovr_n = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        state_n = START;
        cnt_n = (baud_div >> 1) - DIV_W'(1);
      end
      START: if (!cnt_zero) cnt_n = cnt - DIV_W'(1);
      else if (!rxs) begin
        state_n = DATA;
        cnt_n = div_q - DIV_W'(1);
        bidx_n = 3'd0;
      end else state_n = IDLE;
      DATA: if (!cnt_zero) cnt_n = cnt - DIV_W'(1);
      else begin
        shreg_n = {rxs, shreg[7:1]};
        cnt_n = div_q - DIV_W'(1);
        bidx_n = bidx + 3'd1;
        state_n = bidx == 3'd7 ? STOP : DATA;
      end
      STOP: if (!cnt_zero) cnt_n = cnt - DIV_W'(1);
      else if (!rxs) begin
        ferr_n = 1'b1;
        state_n = BRK;
      end else begin
        state_n = IDLE;
        push = !full || pop;
        ovr_n = full && !pop;
      end
      BRK: state_n = rxs ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rxs <= 1'b1;
      cnt <= '0;
      div_q <= '0;
      bidx <= '0;
      shreg <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      err_cnt <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      rx_m <= rxd;
      rxs <= rx_m;
      cnt <= cnt_n;
      bidx <= bidx_n;
      shreg <= shreg_n;
      frame_err <= ferr_n;
      overrun <= ovr_n;
      if (state == IDLE && !rxs) div_q <= baud_div;
      if ((ferr_n || ovr_n) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (push) begin
        mem[wp] <= shreg;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule
